pcie_tx_arb: RTL and testbench

- Two-requester arbiter for the single 16-bit PCIe transmit interface: tx_req, tx_rdy, tx_st, tx_end and tx_data.
- Requester 0 is the completion generator (memory-read responses). Requester 1 is the posted-write/message source (future DMA/NUMA write engine).
- Round-robin grant at packet granularity. Owns the core-side tx_req/tx_rdy handshake and muxes the owner's word stream to the core with one registered stage.
- Watchdog guards against a granted requester that never starts or never ends its packet.

---
 rtl/pcie_pkg.sv | 51 +++++
 rtl/pcie_tx_wdog.sv | 47 ++++
 rtl/pcie_tx_arb.sv | 187 ++++++++++++++++++
 tb/tb_pcie_tx_arb.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/pcie_pkg.sv
// pcie_pkg: definitions shared by the PCIe transmit arbiter and the TLP engine.
//   - arb_state_e : transmit arbiter state encodings (3-bit)
//   - TLP_*       : TLP fmt/type command codes
//   - RX_*/TX_*   : TLP engine receive/transmit state constants
//   - rr_pick     : two-way round-robin selection helper
package pcie_pkg;

    typedef enum logic [2:0] {
        ARB_IDLE   = 3'd0,
        ARB_REQ    = 3'd1,
        ARB_WAITST = 3'd2,
        ARB_XFER   = 3'd3,
        ARB_FLUSH  = 3'd4
    } arb_state_e;

    // TLP fmt/type command codes
    localparam logic [7:0] TLP_MRD32 = 8'h00;
    localparam logic [7:0] TLP_MRD64 = 8'h20;
    localparam logic [7:0] TLP_MWR32 = 8'h40;
    localparam logic [7:0] TLP_MWR64 = 8'h60;
    localparam logic [7:0] TLP_MSG   = 8'h30;
    localparam logic [7:0] TLP_CPL   = 8'h0A;
    localparam logic [7:0] TLP_CPLD  = 8'h4A;

    // TLP engine receive states
    localparam logic [2:0] RX_IDLE = 3'd0;
    localparam logic [2:0] RX_HDR  = 3'd1;
    localparam logic [2:0] RX_DATA = 3'd2;
    localparam logic [2:0] RX_DONE = 3'd3;

    // TLP engine transmit states
    localparam logic [2:0] TX_IDLE = 3'd0;
    localparam logic [2:0] TX_HDR  = 3'd1;
    localparam logic [2:0] TX_DATA = 3'd2;
    localparam logic [2:0] TX_DONE = 3'd3;

    // Round-robin pick: on a tie the requester not served last wins,
    // a lone requester always wins.
    function automatic logic rr_pick(input logic req0, input logic req1, input logic last);
        logic pick;
        if (req0 && req1) begin
            pick = ~last;
        end else if (req1) begin
            pick = 1'b1;
        end else begin
            pick = 1'b0;
        end
        return pick;
    endfunction

endpackage

// File: rtl/pcie_tx_wdog.sv
// pcie_tx_wdog: saturating watchdog counter for the transmit arbiter.
//   pcie_clk, sys_rst : clock, synchronous active-high reset
//   clr               : reload the counter with zero (state change)
//   tmo_start         : start-strobe wait has used its full START_TMO cycles
//   tmo_pkt           : packet has forwarded PKT_TMO words without an end strobe
module pcie_tx_wdog
    import pcie_pkg::*;
#(
    parameter int START_TMO = 16,
    parameter int PKT_TMO   = 1024,
    parameter int CNT_W     = 11
) (
    input  logic pcie_clk,
    input  logic sys_rst,
    input  logic clr,
    output logic tmo_start,
    output logic tmo_pkt
);

    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    // Count 0 is the first waiting cycle, so the last allowed cycle is START_TMO-1.
    localparam logic [CNT_W-1:0] START_LIM = CNT_W'(START_TMO - 1);
    // The start word is taken before the transfer state is entered and the
    // current cycle carries one more word, so count+2 words are out when
    // the count equals PKT_TMO-2.
    localparam logic [CNT_W-1:0] PKT_LIM   = CNT_W'(PKT_TMO - 2);

    logic [CNT_W-1:0] cnt_r;

    // Watchdog counter: clears on reload, otherwise counts up and saturates.
    always_ff @(posedge pcie_clk) begin
        if (sys_rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (cnt_r != CNT_MAX) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign tmo_start = (cnt_r >= START_LIM);
    assign tmo_pkt   = (cnt_r >= PKT_LIM);

endmodule

// File: rtl/pcie_tx_arb.sv
// pcie_tx_arb: packet-granular round-robin arbiter for the 16-bit PCIe
// transmit interface, with a start/packet watchdog.
//   pcie_clk, sys_rst          : clock, synchronous active-high reset
//   m0_* / m1_*                : requester req/gnt handshake and st/end/data stream
//   tx_req, tx_rdy             : core-side request handshake
//   tx_st, tx_end, tx_data     : registered word stream to the core
//   busy, owner, err_tmo       : status (not idle, current/last owner, sticky timeout)
module pcie_tx_arb
    import pcie_pkg::*;
#(
    parameter int START_TMO = 16,
    parameter int PKT_TMO   = 1024,
    parameter int CNT_W     = 11
) (
    input  logic        pcie_clk,
    input  logic        sys_rst,
    input  logic        m0_req,
    output logic        m0_gnt,
    input  logic        m0_st,
    input  logic        m0_end,
    input  logic [15:0] m0_data,
    input  logic        m1_req,
    output logic        m1_gnt,
    input  logic        m1_st,
    input  logic        m1_end,
    input  logic [15:0] m1_data,
    output logic        tx_req,
    input  logic        tx_rdy,
    output logic        tx_st,
    output logic        tx_end,
    output logic [15:0] tx_data,
    output logic        busy,
    output logic        owner,
    output logic        err_tmo
);

    arb_state_e  state_r, nxt_state_s;
    logic        owner_r, nxt_owner_s, last_r;
    logic        gnt_s, upd_last_s, set_err_s, cnt_clr_s;
    logic        own_st_s, own_end_s;
    logic [15:0] own_data_s;
    logic        tmo_start_s, tmo_pkt_s;
    logic        tx_req_r, m0_gnt_r, m1_gnt_r, tx_st_r, tx_end_r, busy_r, err_r;
    logic [15:0] tx_data_r;

    pcie_tx_wdog #(
        .START_TMO (START_TMO),
        .PKT_TMO   (PKT_TMO),
        .CNT_W     (CNT_W)
    ) u_wdog (
        .pcie_clk  (pcie_clk),
        .sys_rst   (sys_rst),
        .clr       (cnt_clr_s),
        .tmo_start (tmo_start_s),
        .tmo_pkt   (tmo_pkt_s)
    );

    // Owner stream select; the non-owner's stream never reaches the core.
    always_comb begin
        if (owner_r) begin
            own_st_s   = m1_st;
            own_end_s  = m1_end;
            own_data_s = m1_data;
        end else begin
            own_st_s   = m0_st;
            own_end_s  = m0_end;
            own_data_s = m0_data;
        end
    end

    // Next-state, grant, pointer-update and timeout decisions.
    always_comb begin
        nxt_state_s = state_r;
        nxt_owner_s = owner_r;
        gnt_s       = 1'b0;
        upd_last_s  = 1'b0;
        set_err_s   = 1'b0;
        case (state_r)
            ARB_IDLE: begin
                if (m0_req || m1_req) begin
                    nxt_owner_s = rr_pick(m0_req, m1_req, last_r);
                    nxt_state_s = ARB_REQ;
                end else begin
                    nxt_state_s = ARB_IDLE;
                end
            end
            ARB_REQ: begin
                if (tx_rdy) begin
                    gnt_s       = 1'b1;
                    nxt_state_s = ARB_WAITST;
                end else begin
                    nxt_state_s = ARB_REQ;
                end
            end
            ARB_WAITST: begin
                if (own_st_s) begin
                    if (own_end_s) begin
                        upd_last_s  = 1'b1;
                        nxt_state_s = ARB_IDLE;
                    end else begin
                        nxt_state_s = ARB_XFER;
                    end
                end else if (tmo_start_s) begin
                    set_err_s   = 1'b1;
                    upd_last_s  = 1'b1;
                    nxt_state_s = ARB_IDLE;
                end else begin
                    nxt_state_s = ARB_WAITST;
                end
            end
            ARB_XFER: begin
                if (own_end_s) begin
                    upd_last_s  = 1'b1;
                    nxt_state_s = ARB_IDLE;
                end else if (tmo_pkt_s) begin
                    nxt_state_s = ARB_FLUSH;
                end else begin
                    nxt_state_s = ARB_XFER;
                end
            end
            ARB_FLUSH: begin
                set_err_s   = 1'b1;
                upd_last_s  = 1'b1;
                nxt_state_s = ARB_IDLE;
            end
            default: begin
                nxt_state_s = ARB_IDLE;
            end
        endcase
    end

    assign cnt_clr_s = (nxt_state_s != state_r);

    // State, handshake, status and registered data-path stage.
    always_ff @(posedge pcie_clk) begin
        if (sys_rst) begin
            state_r   <= ARB_IDLE;
            owner_r   <= 1'b0;
            last_r    <= 1'b1;
            tx_req_r  <= 1'b0;
            m0_gnt_r  <= 1'b0;
            m1_gnt_r  <= 1'b0;
            tx_st_r   <= 1'b0;
            tx_end_r  <= 1'b0;
            tx_data_r <= 16'h0000;
            busy_r    <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            state_r  <= nxt_state_s;
            owner_r  <= nxt_owner_s;
            tx_req_r <= (nxt_state_s == ARB_REQ);
            m0_gnt_r <= gnt_s & ~owner_r;
            m1_gnt_r <= gnt_s & owner_r;
            busy_r   <= (nxt_state_s != ARB_IDLE);
            err_r    <= err_r | set_err_s;
            if (upd_last_s) begin
                last_r <= owner_r;
            end else begin
                last_r <= last_r;
            end
            if ((state_r == ARB_WAITST) || (state_r == ARB_XFER)) begin
                tx_st_r   <= own_st_s;
                tx_end_r  <= own_end_s;
                tx_data_r <= own_data_s;
            end else if (state_r == ARB_FLUSH) begin
                tx_st_r   <= 1'b0;
                tx_end_r  <= 1'b1;
                tx_data_r <= 16'h0000;
            end else begin
                tx_st_r   <= 1'b0;
                tx_end_r  <= 1'b0;
                tx_data_r <= tx_data_r;
            end
        end
    end

    assign tx_req  = tx_req_r;
    assign m0_gnt  = m0_gnt_r;
    assign m1_gnt  = m1_gnt_r;
    assign tx_st   = tx_st_r;
    assign tx_end  = tx_end_r;
    assign tx_data = tx_data_r;
    assign busy    = busy_r;
    assign owner   = owner_r;
    assign err_tmo = err_r;

endmodule

// File: tb/tb_pcie_tx_arb.sv
// tb_pcie_tx_arb: directed self-checking bench for pcie_tx_arb.
module tb_pcie_tx_arb;

    logic        pcie_clk = 1'b0;
    logic        sys_rst  = 1'b1;
    logic        m0_req = 1'b0, m0_st = 1'b0, m0_end = 1'b0;
    logic [15:0] m0_data = 16'h0000;
    logic        m1_req = 1'b0, m1_st = 1'b0, m1_end = 1'b0;
    logic [15:0] m1_data = 16'h0000;
    logic        tx_rdy = 1'b0;
    logic        m0_gnt, m1_gnt, tx_req, tx_st, tx_end, busy, owner, err_tmo;
    logic [15:0] tx_data;

    int n_cmp = 0;
    int n_mis = 0;

    pcie_tx_arb dut (
        .pcie_clk (pcie_clk),
        .sys_rst  (sys_rst),
        .m0_req   (m0_req),
        .m0_gnt   (m0_gnt),
        .m0_st    (m0_st),
        .m0_end   (m0_end),
        .m0_data  (m0_data),
        .m1_req   (m1_req),
        .m1_gnt   (m1_gnt),
        .m1_st    (m1_st),
        .m1_end   (m1_end),
        .m1_data  (m1_data),
        .tx_req   (tx_req),
        .tx_rdy   (tx_rdy),
        .tx_st    (tx_st),
        .tx_end   (tx_end),
        .tx_data  (tx_data),
        .busy     (busy),
        .owner    (owner),
        .err_tmo  (err_tmo)
    );

    always #5 pcie_clk = ~pcie_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled and inputs driven 1 time unit after the edge.
    task automatic tick();
        @(posedge pcie_clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_tx_req"}, {31'd0, tx_req}, 32'd0);
        check_eq({tag, "_gnt"}, {30'd0, m1_gnt, m0_gnt}, 32'd0);
        check_eq({tag, "_st_end"}, {30'd0, tx_st, tx_end}, 32'd0);
        check_eq({tag, "_data"}, {16'd0, tx_data}, 32'd0);
        check_eq({tag, "_busy_own_err"}, {29'd0, busy, owner, err_tmo}, 32'd0);
    endtask

    // From ARB_IDLE with requests driven: arbitration, wait_cyc extra cycles
    // without tx_rdy, then the tx_rdy cycle and the grant pulse.
    task automatic grant(input logic exp_own, input int wait_cyc);
        tick();
        check_eq("arb_owner", {31'd0, owner}, {31'd0, exp_own});
        check_eq("arb_tx_req", {31'd0, tx_req}, 32'd1);
        check_eq("arb_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < wait_cyc; i++) begin
            tick();
            check_eq("req_hold", {31'd0, tx_req}, 32'd1);
            check_eq("req_nognt", {30'd0, m1_gnt, m0_gnt}, 32'd0);
        end
        tx_rdy = 1'b1;
        tick();
        tx_rdy = 1'b0;
        check_eq("gnt_tx_req", {31'd0, tx_req}, 32'd0);
        check_eq("gnt_pulse", {30'd0, m1_gnt, m0_gnt}, exp_own ? 32'd2 : 32'd1);
    endtask

    // Drive word w of an n-word packet on requester own; optional noise on the other one.
    task automatic drive(input logic own, input int w, input int n, input logic [15:0] d, input logic noise);
        if (own) begin
            m1_st = (w == 0); m1_end = (w == n - 1); m1_data = d;
            m0_st = noise; m0_end = noise; m0_data = noise ? 16'hDEAD : 16'h0000;
        end else begin
            m0_st = (w == 0); m0_end = (w == n - 1); m0_data = d;
            m1_st = noise; m1_end = noise; m1_data = noise ? 16'hDEAD : 16'h0000;
        end
    endtask

    task automatic clear_streams();
        m0_st = 1'b0; m0_end = 1'b0; m0_data = 16'h0000;
        m1_st = 1'b0; m1_end = 1'b0; m1_data = 16'h0000;
    endtask

    // Send an n-word packet starting right after the grant; checks 1-cycle latency.
    task automatic words(input logic own, input int n, input logic [15:0] base, input logic noise);
        for (int w = 0; w < n; w++) begin
            drive(own, w, n, base + 16'(w), noise);
            tick();
            check_eq("word_data", {16'd0, tx_data}, {16'd0, base + 16'(w)});
            check_eq("word_st_end", {30'd0, tx_st, tx_end}, {30'd0, (w == 0), (w == n - 1)});
            if (w == 0) begin
                check_eq("gnt_one_cycle", {30'd0, m1_gnt, m0_gnt}, 32'd0);
            end
        end
        clear_streams();
        check_eq("pkt_done_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check_reset_outputs("reset");
        sys_rst = 1'b0;

        // Single requester, tx_rdy after 3 request cycles, 8-word packet
        m0_req = 1'b1;
        grant(1'b0, 2);
        m0_req = 1'b0;
        words(1'b0, 8, 16'hA000, 1'b0);

        // Both requesting from reset: m0, m1, m0, m1; m1 packets carry m0 noise
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        m0_req = 1'b1;
        m1_req = 1'b1;
        for (int p = 0; p < 4; p++) begin
            grant(p[0], 0);
            words(p[0], 3, 16'h0100 * 16'(p + 1), p[0]);
        end

        // Start timeout: m0 (next in turn) never starts
        grant(1'b0, 0);
        for (int i = 0; i < 15; i++) begin
            tick();
            check_eq("tmo_wait_err", {31'd0, err_tmo}, 32'd0);
            check_eq("tmo_wait_st", {31'd0, tx_st}, 32'd0);
            check_eq("tmo_wait_busy", {31'd0, busy}, 32'd1);
        end
        tick();
        check_eq("tmo_err", {31'd0, err_tmo}, 32'd1);
        check_eq("tmo_busy", {31'd0, busy}, 32'd0);
        check_eq("tmo_st", {31'd0, tx_st}, 32'd0);
        grant(1'b1, 0);
        m0_req = 1'b0;
        m1_req = 1'b0;
        words(1'b1, 3, 16'h5000, 1'b0);
        check_eq("tmo_sticky", {31'd0, err_tmo}, 32'd1);

        // Packet timeout: 1100 words without end
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        check_eq("rst_err_clr", {31'd0, err_tmo}, 32'd0);
        m0_req = 1'b1;
        grant(1'b0, 0);
        m0_req = 1'b0;
        for (int w = 0; w < 1100; w++) begin
            m0_st = (w == 0); m0_end = 1'b0; m0_data = 16'h1000 + 16'(w);
            tick();
            if (w < 1024) begin
                check_eq("long_data", {16'd0, tx_data}, {16'd0, 16'h1000 + 16'(w)});
                check_eq("long_st_end", {30'd0, tx_st, tx_end}, {30'd0, (w == 0), 1'b0});
                check_eq("long_err", {31'd0, err_tmo}, 32'd0);
            end else if (w == 1024) begin
                check_eq("flush_end", {31'd0, tx_end}, 32'd1);
                check_eq("flush_data", {16'd0, tx_data}, 32'd0);
                check_eq("flush_err", {31'd0, err_tmo}, 32'd1);
                check_eq("flush_busy", {31'd0, busy}, 32'd0);
            end else begin
                check_eq("post_flush", {29'd0, tx_st, tx_end, busy}, 32'd0);
            end
        end
        clear_streams();

        // Reset mid-transfer, then pointer back to requester 0
        m1_req = 1'b1;
        grant(1'b1, 0);
        m1_req = 1'b0;
        for (int w = 0; w < 4; w++) begin
            drive(1'b1, w, 100, 16'h7000 + 16'(w), 1'b0);
            tick();
            check_eq("mid_data", {16'd0, tx_data}, {16'd0, 16'h7000 + 16'(w)});
        end
        drive(1'b1, 4, 100, 16'h7004, 1'b0);
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        clear_streams();
        check_reset_outputs("mid_rst");
        m0_req = 1'b1;
        m1_req = 1'b1;
        grant(1'b0, 0);
        m0_req = 1'b0;
        words(1'b0, 2, 16'h8000, 1'b0);
        grant(1'b1, 0);
        m1_req = 1'b0;
        words(1'b1, 2, 16'h9000, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
